hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order integer pipeline; generalises per-operand forwarding selection to NUM_SRC operands and FWD_STAGES forwarding stages, and adds producer latency classes. A per-register scoreboard tracks the age and latency of every in-flight write. It decides in ID whether each operand can be forwarded, must be read from the register file, or must stall issue (for example load-use). It registers the forward selects into EX alongside the issuing instruction.

## Interface
- NUM_SRC, 2, source operands per instruction
- FWD_STAGES, 2, forwardable stages after EX (stage 1 = MEM, stage 2 = WB)
- ADDR_W, 5, register address width; scoreboard has 2**ADDR_W entries, entry 0 unused
- SEL_W, $clog2(FWD_STAGES+1), derived; width of one select / age / latency field
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- hold  in  1  whole-pipeline freeze (memory wait)
- id_valid  in  1  instruction present in ID
- id_src_addr  in  NUM_SRC*ADDR_W  source register addresses, operand i at [i*ADDR_W +: ADDR_W]
- id_src_used  in  NUM_SRC  operand i actually read
- id_RegWrite  in  1  ID instruction writes rd
- id_rd_addr  in  ADDR_W  destination register
- id_lat  in  SEL_W  producer latency class: first stage index whose result is forwardable (1 = ALU, 2 = load)
- id_stall  out  1  hold ID/IF this cycle (combinational)
- ex_valid  out  1  registered; instruction issued into EX
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered; per operand: 0 = register file, k = forward from stage k

## Operation
- Scoreboard entry r: busy, age (SEL_W), lat (SEL_W).
- Match for operand i: id_valid && id_src_used[i] && src != 0 && busy[src].
- Hazard for operand i: match && age[src] < lat[src].
- id_stall = any operand hazard, ORed with hold.
- issue = id_valid && !id_stall && !hold.
- On issue, ex_fwd_sel[i] = age[src] when matched, otherwise 0; ex_valid = 1.
- When no issue and !hold: ex_valid = 0 and ex_fwd_sel = 0 (bubble).
- When hold: ex_valid and ex_fwd_sel retain their values.
- Each non-hold cycle, every busy entry: age++. An entry whose age equals FWD_STAGES clears busy instead (value is now in the register file).
- On issue with id_RegWrite && rd != 0: entry rd gets busy = 1, age = 1, lat = id_lat. This overrides any older entry for rd, so the newest producer wins. It also takes precedence over that entry's own age++/retire in the same cycle.
- id_lat of 0 is treated as 1; values above FWD_STAGES are clamped to FWD_STAGES.
- Hazard evaluation reads the pre-update state, so an instruction whose rd equals its own src sees the older producer.
- The register file is write-through: a value retired at age FWD_STAGES is readable by a consumer issuing in the next cycle.

## Timing
- Reset (asynchronous, immediate): all busy = 0, age = 0, lat = 0, ex_valid = 0, ex_fwd_sel = 0; id_stall is therefore 0 whenever hold = 0.
- Reset mid-operation discards all tracking; no stall is carried across reset.
- Issue latency is 1 cycle: decision in ID at cycle u, ex_valid/ex_fwd_sel visible at u+1.
- Producer issued at t, consumer at u: age seen = u−t. Outcomes:
  - Forward from stage u−t if lat ≤ u−t ≤ FWD_STAGES.
  - Stall while u−t < lat.
  - Register file if u−t > FWD_STAGES.
- With defaults:
  - ALU→use never stalls.
  - Load→use stalls exactly 1 cycle.
  - Load→use at distance 2 forwards from WB without stall.
- hold freezes ages, so a pending stall resolves after the same number of non-hold cycles.

## Structure
- Shared pipeline include carries the latency-class constants (LAT_ALU = 1, LAT_LOAD = 2) and the select encoding constants (FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2).
- The EX operand muxes and the decoder use these same constants.
- One natural sub-module: hazard_sb_entry, holding one register's busy/age/lat with its update/retire logic. It is generated 2**ADDR_W − 1 times.
- The top level holds the NUM_SRC lookup/compare and the EX output registers.

## Test plan
- ALU producer x5 (lat 1) issued at t; consumer rs1 = x5 at t+1 → id_stall = 0; at t+2, ex_fwd_sel[0] = 1 and ex_valid = 1.
- Load x6 (lat 2) at t; consumer rs2 = x6 at t+1 → id_stall = 1 for one cycle, ex_valid = 0 at t+2; consumer issues at t+2 with ex_fwd_sel[1] = 2 at t+3.
- Producer x8 at t; consumer at t+3 → ex_fwd_sel = 0 and busy[8] cleared. Consumer reading x0 after a write to x0 → sel 0, never stalls.
- x7 ALU at t, then x7 load at t+1; consumer at t+2 → stalls one cycle (newest entry wins), then issues with sel = 2.
- Load-use stall with hold = 1 for 3 cycles → id_stall stays 1, ages frozen, ex outputs unchanged; after hold drops, the stall lasts the same one cycle.
- Several entries busy and stall active, then reset asserted between edges → id_stall, ex_valid, ex_fwd_sel go to 0 immediately; after release, a former load-use pair issues with sel 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants: producer latency classes and forward-select encoding.
// Used by the scoreboard, the decoder and the EX operand muxes alike.
package hazard_scoreboard_pkg;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    // A latency of 0 behaves like an ALU result; anything slower than the
    // last forwardable stage is only ever seen there.
    function automatic int clamp_lat(input int lat, input int max_stage);
        if (lat < LAT_ALU) begin
            return LAT_ALU;
        end
        if (lat > max_stage) begin
            return max_stage;
        end
        return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / EX-stage select bundle between the decoder and the scoreboard.
// master = instruction source (decoder), slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int ADDR_W     = 5
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic                      hold;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_RegWrite;
    logic [ADDR_W-1:0]         id_rd_addr;
    logic [SEL_W-1:0]          id_lat;
    logic                      id_stall;
    logic                      ex_valid;
    logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;

    modport master (
        output hold, id_valid, id_src_addr, id_src_used, id_RegWrite, id_rd_addr, id_lat,
        input  id_stall, ex_valid, ex_fwd_sel
    );

    modport slave (
        input  hold, id_valid, id_src_addr, id_src_used, id_RegWrite, id_rd_addr, id_lat,
        output id_stall, ex_valid, ex_fwd_sel
    );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: tracks the newest in-flight write to a single register.
// Age advances every non-hold cycle; the entry retires once it reaches the last forward stage.
module hazard_sb_entry #(
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             set,
    input  logic [SEL_W-1:0] set_lat,
    output logic             busy,
    output logic [SEL_W-1:0] age,
    output logic [SEL_W-1:0] lat
);

    logic             busy_reg;
    logic [SEL_W-1:0] age_reg;
    logic [SEL_W-1:0] lat_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= 1'b0;
            age_reg  <= '0;
            lat_reg  <= '0;
        end else if (!hold) begin
            // A new producer replaces whatever this entry was tracking.
            if (set) begin
                busy_reg <= 1'b1;
                age_reg  <= SEL_W'(1);
                lat_reg  <= set_lat;
            end else if (busy_reg) begin
                if (age_reg == SEL_W'(FWD_STAGES)) begin
                    busy_reg <= 1'b0;
                end else begin
                    age_reg <= age_reg + SEL_W'(1);
                end
            end
        end
    end

    assign busy = busy_reg;
    assign age  = age_reg;
    assign lat  = lat_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: per-operand scoreboard lookup in ID, stall decision,
// and registered forward selects delivered to EX with the issuing instruction.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int ADDR_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    localparam int SEL_W    = $clog2(FWD_STAGES + 1);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic             busy [NUM_REGS];
    logic [SEL_W-1:0] age  [NUM_REGS];
    logic [SEL_W-1:0] lat  [NUM_REGS];

    logic [NUM_SRC-1:0]       hazard;
    logic [NUM_SRC*SEL_W-1:0] sel_next;
    logic [SEL_W-1:0]         lat_eff;
    logic                     issue;

    logic                     ex_valid_reg;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_reg;

    // x0 is hard-wired zero and never produces a hazard.
    assign busy[0] = 1'b0;
    assign age[0]  = '0;
    assign lat[0]  = '0;

    assign lat_eff = SEL_W'(clamp_lat(int'(bus.id_lat), FWD_STAGES));

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            hazard_sb_entry #(
                .FWD_STAGES (FWD_STAGES),
                .SEL_W      (SEL_W)
            ) u_entry (
                .clk     (clk),
                .reset   (reset),
                .hold    (bus.hold),
                .set     (issue && bus.id_RegWrite && (bus.id_rd_addr == ADDR_W'(gi))),
                .set_lat (lat_eff),
                .busy    (busy[gi]),
                .age     (age[gi]),
                .lat     (lat[gi])
            );
        end

        // Lookups use the pre-update scoreboard, so rd == src sees the older producer.
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [ADDR_W-1:0] src;
            logic              match;

            assign src   = bus.id_src_addr[gi*ADDR_W +: ADDR_W];
            assign match = bus.id_valid && bus.id_src_used[gi] && (src != '0) && busy[src];
            assign hazard[gi] = match && (age[src] < lat[src]);
            assign sel_next[gi*SEL_W +: SEL_W] = match ? age[src] : SEL_W'(FWD_RF);
        end
    endgenerate

    assign issue        = bus.id_valid && !(|hazard) && !bus.hold;
    assign bus.id_stall = (|hazard) || bus.hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_reg   <= 1'b0;
            ex_fwd_sel_reg <= '0;
        end else if (!bus.hold) begin
            ex_valid_reg   <= issue;
            ex_fwd_sel_reg <= issue ? sel_next : '0;
        end
    end

    assign bus.ex_valid   = ex_valid_reg;
    assign bus.ex_fwd_sel = ex_fwd_sel_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus random
// traffic compared against an issue-time based reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 2;
    localparam int ADDR_W     = 5;
    localparam int SEL_W      = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .ADDR_W(ADDR_W)) bus ();

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remembers when (in non-hold cycles) each register's newest
    // producer issued and its latency; the distance alone decides the outcome.
    bit m_busy [32];
    int m_t    [32];
    int m_lat  [32];
    int now;
    bit e_valid;
    int e_sel  [2];

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 0;
            m_t[r]    = 0;
            m_lat[r]  = 0;
        end
        now      = 0;
        e_valid  = 0;
        e_sel[0] = 0;
        e_sel[1] = 0;
    endtask

    function automatic void model_op(input int src, input bit used, output bit hz, output int sel);
        int d;
        hz  = 0;
        sel = 0;
        if (bus.id_valid && used && src != 0 && m_busy[src]) begin
            d = now - m_t[src];
            if (d <= FWD_STAGES) begin
                if (d < m_lat[src]) hz = 1;
                else                sel = d;
            end
        end
    endfunction

    function automatic bit model_stall();
        bit h0, h1;
        int s0, s1;
        model_op(int'(bus.id_src_addr[4:0]), bus.id_src_used[0], h0, s0);
        model_op(int'(bus.id_src_addr[9:5]), bus.id_src_used[1], h1, s1);
        return h0 || h1 || bus.hold;
    endfunction

    // Advance one clock: model decides from the inputs in force before the edge.
    task automatic advance();
        bit h0, h1, iss, rw;
        int s0, s1, rd, l;
        model_op(int'(bus.id_src_addr[4:0]), bus.id_src_used[0], h0, s0);
        model_op(int'(bus.id_src_addr[9:5]), bus.id_src_used[1], h1, s1);
        iss = bus.id_valid && !h0 && !h1 && !bus.hold;
        rw  = bus.id_RegWrite;
        rd  = int'(bus.id_rd_addr);
        l   = int'(bus.id_lat);
        if (l == 0) l = 1;
        if (l > FWD_STAGES) l = FWD_STAGES;
        @(posedge clk);
        if (!bus.hold) begin
            e_valid  = iss;
            e_sel[0] = iss ? s0 : 0;
            e_sel[1] = iss ? s1 : 0;
            if (iss && rw && rd != 0) begin
                m_busy[rd] = 1;
                m_t[rd]    = now;
                m_lat[rd]  = l;
            end
            now++;
        end
        #1;
    endtask

    task automatic set_in(bit v, int s0, int s1, bit [1:0] used, bit rw, int rd, int lt);
        bus.id_valid    = v;
        bus.id_src_addr = {ADDR_W'(s1), ADDR_W'(s0)};
        bus.id_src_used = used;
        bus.id_RegWrite = rw;
        bus.id_rd_addr  = ADDR_W'(rd);
        bus.id_lat      = SEL_W'(lt);
        #1;
    endtask

    task automatic flush();
        set_in(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) advance();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.hold = 1'b0;
        set_in(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks += 3;
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", bus.id_stall); end
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %0b expected 0", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd_sel: got %b expected 0000", bus.ex_fwd_sel); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_alu_fwd();
        set_in(1, 0, 0, 2'b00, 1, 5, LAT_ALU);
        advance();
        set_in(1, 5, 0, 2'b01, 0, 0, 0);
        n_checks++;
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL alu_use_stall: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL alu_use_valid: got %0b expected 1", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL alu_use_sel: got %b expected 0001", bus.ex_fwd_sel); end
        flush();
        $display("test_alu_fwd done");
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 2'b00, 1, 6, LAT_LOAD);
        advance();
        set_in(1, 0, 6, 2'b10, 0, 0, 0);
        n_checks++;
        if (bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %0b expected 1", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %0b expected 0", bus.ex_valid); end
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL load_use_valid: got %0b expected 1", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL load_use_sel: got %b expected 1000", bus.ex_fwd_sel); end
        flush();
        $display("test_load_use done");
    endtask

    task automatic test_retire_x0();
        set_in(1, 0, 0, 2'b00, 1, 8, LAT_LOAD);
        advance();
        set_in(0, 0, 0, 2'b00, 0, 0, 0);
        repeat (2) advance();
        set_in(1, 8, 8, 2'b11, 0, 0, 0);
        n_checks++;
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL retire_stall: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks++;
        if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL retire_sel: got %b expected 0000", bus.ex_fwd_sel); end
        set_in(1, 0, 0, 2'b00, 1, 0, LAT_LOAD);
        advance();
        set_in(1, 0, 0, 2'b11, 0, 0, 0);
        n_checks++;
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL x0_valid: got %0b expected 1", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL x0_sel: got %b expected 0000", bus.ex_fwd_sel); end
        flush();
        $display("test_retire_x0 done");
    endtask

    task automatic test_newest_wins();
        set_in(1, 0, 0, 2'b00, 1, 7, LAT_ALU);
        advance();
        set_in(1, 0, 0, 2'b00, 1, 7, LAT_LOAD);
        advance();
        set_in(1, 7, 0, 2'b01, 0, 0, 0);
        n_checks++;
        if (bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL newest_stall: got %0b expected 1", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL newest_bubble: got %0b expected 0", bus.ex_valid); end
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL newest_release: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks++;
        if (bus.ex_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL newest_sel: got %b expected 0010", bus.ex_fwd_sel); end
        flush();
        $display("test_newest_wins done");
    endtask

    task automatic test_hold();
        set_in(1, 0, 0, 2'b00, 1, 6, LAT_LOAD);
        advance();
        set_in(1, 0, 6, 2'b10, 0, 0, 0);
        bus.hold = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks += 3;
            if (bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %0b expected 1", c, bus.id_stall); end
            if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b expected 1", c, bus.ex_valid); end
            if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL hold_sel[%0d]: got %b expected 0000", c, bus.ex_fwd_sel); end
        end
        bus.hold = 1'b0;
        #1;
        n_checks++;
        if (bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL hold_after_stall: got %0b expected 1", bus.id_stall); end
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL hold_after_bubble: got %0b expected 0", bus.ex_valid); end
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL hold_after_release: got %0b expected 0", bus.id_stall); end
        advance();
        n_checks++;
        if (bus.ex_fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL hold_after_sel: got %b expected 1000", bus.ex_fwd_sel); end
        flush();
        $display("test_hold done");
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 0, 2'b00, 1, 6, LAT_LOAD);
        advance();
        set_in(1, 0, 0, 2'b00, 1, 10, LAT_LOAD);
        advance();
        set_in(1, 10, 6, 2'b11, 0, 0, 0);
        n_checks += 2;
        if (bus.id_stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall: got %0b expected 1", bus.id_stall); end
        if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b expected 1", bus.ex_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_checks += 3;
        if (bus.id_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %0b expected 0", bus.id_stall); end
        if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b expected 0", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_sel: got %b expected 0000", bus.ex_fwd_sel); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        advance();
        n_checks += 2;
        if (bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL mid_post_valid: got %0b expected 1", bus.ex_valid); end
        if (bus.ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL mid_post_sel: got %b expected 0000", bus.ex_fwd_sel); end
        flush();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.hold = ($urandom_range(0, 9) == 0);
            set_in(($urandom_range(0, 4) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 3));
            n_checks++;
            if (bus.id_stall !== model_stall()) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: got %0b expected %0b", n, bus.id_stall, model_stall());
            end
            advance();
            n_checks += 2;
            if (bus.ex_valid !== e_valid) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %0b expected %0b", n, bus.ex_valid, e_valid);
            end
            if (bus.ex_fwd_sel !== {SEL_W'(e_sel[1]), SEL_W'(e_sel[0])}) begin
                n_fail++;
                $display("FAIL rand_sel[%0d]: got %b expected %0d/%0d", n, bus.ex_fwd_sel, e_sel[1], e_sel[0]);
            end
        end
        bus.hold = 1'b0;
        $display("test_random done: 400 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_retire_x0();
        test_newest_wins();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
